rll_key_loader: RTL and testbench

//  Upstream key-provisioning stage for the RLL-locked combinational netlists (16 key inputs).

---
 rtl/rll_key_pkg.sv | 30 +++
 rtl/rll_key_timeout.sv | 44 ++++
 rtl/rll_key_loader.sv | 196 +++++++++++++++++++
 tb/tb_rll_key_loader.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rll_key_pkg.sv
// Shared types and constants for the RLL key loader.
package rll_key_pkg;

    // Default build parameters: 16 key inputs on the locked netlist.
    localparam int KEY_WIDTH_DEF   = 16;
    localparam int MAX_RETRY_DEF   = 3;
    localparam int TIMEOUT_CYC_DEF = 255;

    // Loader states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHIFT  = 3'd1,
        ST_PARITY = 3'd2,
        ST_LOCKED = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    // err_code values.
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_PARITY  = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    // Width of a counter that must hold values 0..max_value.
    function automatic int cnt_width(input int max_value);
        int w;
        w = $clog2(max_value + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rll_key_timeout.sv
// Idle-cycle watchdog: counts consecutive enabled cycles since the last clear
// and flags the cycle on which the idle run reaches TIMEOUT_CYC.
module rll_key_timeout
    import rll_key_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int TW = cnt_width(TIMEOUT_CYC);
    localparam logic [TW-1:0] LAST_IDLE = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] count_reg;
    logic [TW-1:0] count_next;

    // expired fires combinationally on the idle cycle that completes the run,
    // so the loader leaves on that same edge; a clear (beat) always wins.
    assign expired = enable && !clear && (count_reg == LAST_IDLE);

    // Next count: clear, otherwise count enabled cycles, saturating at the limit.
    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (enable && (count_reg != LAST_IDLE)) begin
            count_next = count_reg + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/rll_key_loader.sv
// Bit-serial key loader for RLL-locked netlists: shifts in KEY_WIDTH key bits
// LSB first plus one even-parity bit, retries on parity failure, and only
// publishes the key on key_out once a parity-clean frame has been captured.
module rll_key_loader
    import rll_key_pkg::*;
#(
    parameter int KEY_WIDTH   = KEY_WIDTH_DEF,
    parameter int MAX_RETRY   = MAX_RETRY_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 zeroize,
    input  logic                 ser_valid,
    input  logic                 ser_bit,
    output logic                 ser_ready,
    output logic [KEY_WIDTH-1:0] key_out,
    output logic                 key_valid,
    output logic                 busy,
    output logic                 err,
    output logic [1:0]           err_code
);

    localparam int BW = cnt_width(KEY_WIDTH - 1);
    localparam int RW = cnt_width(MAX_RETRY);
    localparam logic [BW-1:0] LAST_BIT  = BW'(KEY_WIDTH - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    state_t                 state_reg,     state_next;
    logic [KEY_WIDTH-1:0]   shreg_reg,     shreg_next;
    logic [BW-1:0]          bit_cnt_reg,   bit_cnt_next;
    logic [RW-1:0]          retry_reg,     retry_next;
    logic [KEY_WIDTH-1:0]   key_out_reg,   key_out_next;
    logic                   key_valid_reg, key_valid_next;
    logic                   err_reg,       err_next;
    logic [1:0]             err_code_reg,  err_code_next;

    logic                   loading;
    logic                   beat;
    logic                   timer_clear;
    logic                   timer_enable;
    logic                   timer_expired;
    logic [KEY_WIDTH-1:0]   bit_sel;
    logic [KEY_WIDTH-1:0]   shreg_written;
    logic                   frame_parity;

    // Handshake and status decoded straight from the state.
    assign loading   = (state_reg == ST_SHIFT) || (state_reg == ST_PARITY);
    assign ser_ready = loading;
    assign busy      = loading;
    assign beat      = ser_valid && loading;

    assign key_out   = key_out_reg;
    assign key_valid = key_valid_reg;
    assign err       = err_reg;
    assign err_code  = err_code_reg;

    // One-hot select of the shift-register bit addressed by bit_cnt.
    generate
        for (genvar gi = 0; gi < KEY_WIDTH; gi++) begin : g_bit_sel
            assign bit_sel[gi] = (bit_cnt_reg == BW'(gi));
        end
    endgenerate

    // Shift register with the current serial bit dropped into its slot.
    assign shreg_written = (shreg_reg & ~bit_sel) | (bit_sel & {KEY_WIDTH{ser_bit}});

    // Even parity over the captured key and the incoming parity bit; 0 = clean.
    assign frame_parity = ^{shreg_reg, ser_bit};

    // Watchdog runs only while loading and restarts on every beat.
    assign timer_clear  = !loading || beat;
    assign timer_enable = loading && !beat;

    rll_key_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    // Next-state and datapath decode; zeroize overrides everything else.
    always_comb begin
        state_next     = state_reg;
        shreg_next     = shreg_reg;
        bit_cnt_next   = bit_cnt_reg;
        retry_next     = retry_reg;
        key_out_next   = key_out_reg;
        key_valid_next = key_valid_reg;
        err_next       = err_reg;
        err_code_next  = err_code_reg;

        if (zeroize) begin
            state_next     = ST_IDLE;
            shreg_next     = '0;
            bit_cnt_next   = '0;
            retry_next     = '0;
            key_out_next   = '0;
            key_valid_next = 1'b0;
            err_next       = 1'b0;
            err_code_next  = ERR_NONE;
        end else begin
            case (state_reg)
                ST_IDLE, ST_ERROR: begin
                    if (start) begin
                        state_next     = ST_SHIFT;
                        shreg_next     = '0;
                        bit_cnt_next   = '0;
                        retry_next     = '0;
                        key_out_next   = '0;
                        key_valid_next = 1'b0;
                        err_next       = 1'b0;
                        err_code_next  = ERR_NONE;
                    end
                end

                ST_SHIFT: begin
                    if (beat) begin
                        shreg_next = shreg_written;
                        if (bit_cnt_reg == LAST_BIT) begin
                            bit_cnt_next = '0;
                            state_next   = ST_PARITY;
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 1'b1;
                        end
                    end else if (timer_expired) begin
                        state_next    = ST_ERROR;
                        err_next      = 1'b1;
                        err_code_next = ERR_TIMEOUT;
                    end
                end

                ST_PARITY: begin
                    if (beat) begin
                        if (!frame_parity) begin
                            state_next     = ST_LOCKED;
                            key_out_next   = shreg_reg;
                            key_valid_next = 1'b1;
                        end else if (retry_reg < RETRY_MAX) begin
                            state_next   = ST_SHIFT;
                            retry_next   = retry_reg + 1'b1;
                            shreg_next   = '0;
                            bit_cnt_next = '0;
                        end else begin
                            state_next     = ST_ERROR;
                            key_out_next   = '0;
                            key_valid_next = 1'b0;
                            err_next       = 1'b1;
                            err_code_next  = ERR_PARITY;
                        end
                    end else if (timer_expired) begin
                        state_next    = ST_ERROR;
                        err_next      = 1'b1;
                        err_code_next = ERR_TIMEOUT;
                    end
                end

                ST_LOCKED: begin
                    // Key held until zeroize or reset; start is ignored.
                end

                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers; reset drops any partial key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            shreg_reg     <= '0;
            bit_cnt_reg   <= '0;
            retry_reg     <= '0;
            key_out_reg   <= '0;
            key_valid_reg <= 1'b0;
            err_reg       <= 1'b0;
            err_code_reg  <= ERR_NONE;
        end else begin
            state_reg     <= state_next;
            shreg_reg     <= shreg_next;
            bit_cnt_reg   <= bit_cnt_next;
            retry_reg     <= retry_next;
            key_out_reg   <= key_out_next;
            key_valid_reg <= key_valid_next;
            err_reg       <= err_next;
            err_code_reg  <= err_code_next;
        end
    end

endmodule

// File: tb/tb_rll_key_loader.sv
// Self-checking bench for rll_key_loader: frame-level reference model for
// retries/parity, plus directed timeout, zeroize and async-reset scenarios.
module tb_rll_key_loader;

    localparam int KW    = 16;
    localparam int FRAME = KW + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          zeroize;
    logic          ser_valid;
    logic          ser_bit;
    logic          ser_ready;
    logic [KW-1:0] key_out;
    logic          key_valid;
    logic          busy;
    logic          err;
    logic [1:0]    err_code;

    int checks = 0;
    int errors = 0;

    // Frames offered by the key store: data plus the parity bit sent after it.
    logic [KW-1:0] fr_key[$];
    logic          fr_par[$];

    always #5 clk = ~clk;

    rll_key_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .zeroize   (zeroize),
        .ser_valid (ser_valid),
        .ser_bit   (ser_bit),
        .ser_ready (ser_ready),
        .key_out   (key_out),
        .key_valid (key_valid),
        .busy      (busy),
        .err       (err),
        .err_code  (err_code)
    );

    function automatic void push_frame(input logic [KW-1:0] k, input bit good);
        fr_key.push_back(k);
        fr_par.push_back(good ? (^k) : ~(^k));
    endfunction

    // Full load from IDLE/ERROR against the queued frames. Reference model:
    // the first of at most MAX_RETRY+1 frames whose 17 bits XOR to zero is the
    // key; if all four fail the loader errors with code 1. Loading lasts
    // exactly 17 beats per frame consumed.
    task automatic do_load(input bit zero_first, input int pct, input bit hold_start,
                           input string name);
        int            exp_idx;
        bit            exp_fail;
        int            total;
        int            beats;
        int            cycles;
        int            f;
        int            pos;
        bit            v;
        logic [KW-1:0] k;
        logic [KW-1:0] exp_key;
        exp_fail = 1'b1;
        exp_idx  = 3;
        exp_key  = '0;
        for (int i = 0; i < fr_key.size() && i < 4; i++) begin
            if ((^fr_key[i]) == fr_par[i]) begin
                exp_idx  = i;
                exp_fail = 1'b0;
                exp_key  = fr_key[i];
                break;
            end
        end
        total = FRAME * (exp_idx + 1);

        if (zero_first) begin
            @(negedge clk);
            zeroize   = 1'b1;
            ser_valid = 1'b1;
            @(negedge clk);
            zeroize   = 1'b0;
            ser_valid = 1'b0;
            checks++;
            if (key_valid !== 1'b0 || key_out !== '0 || err !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL %s zeroize_clear got kv=%b key=%h err=%b busy=%b want 0/0000/0/0",
                         name, key_valid, key_out, err, busy);
            end
        end

        start = 1'b1;
        @(negedge clk);
        if (!hold_start) start = 1'b0;
        beats  = 0;
        cycles = 0;
        while (beats < total && cycles < 4000) begin
            checks++;
            if (ser_ready !== 1'b1 || busy !== 1'b1 || key_valid !== 1'b0 || err !== 1'b0) begin
                errors++;
                $display("FAIL %s loading beat=%0d got rdy=%b busy=%b kv=%b err=%b want 1/1/0/0",
                         name, beats, ser_ready, busy, key_valid, err);
            end
            v   = ($urandom_range(99) < pct);
            f   = beats / FRAME;
            pos = beats % FRAME;
            k   = fr_key[f];
            ser_valid = v;
            ser_bit   = v ? ((pos < KW) ? k[pos] : fr_par[f]) : 1'($urandom);
            @(negedge clk);
            if (v) beats++;
            cycles++;
        end
        ser_valid = 1'b0;
        start     = 1'b0;
        checks++;
        if (cycles >= 4000) begin
            errors++;
            $display("FAIL %s cycle_budget got %0d beats want %0d", name, beats, total);
        end

        checks++;
        if (exp_fail) begin
            if (key_valid !== 1'b0 || key_out !== '0 || err !== 1'b1 || err_code !== 2'd1 ||
                ser_ready !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL %s parity_error got kv=%b key=%h err=%b code=%0d rdy=%b busy=%b want 0/0000/1/1/0/0",
                         name, key_valid, key_out, err, err_code, ser_ready, busy);
            end
        end else begin
            if (key_valid !== 1'b1 || key_out !== exp_key || err !== 1'b0 || err_code !== 2'd0 ||
                ser_ready !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL %s locked got kv=%b key=%h err=%b code=%0d rdy=%b busy=%b want 1/%h/0/0/0/0",
                         name, key_valid, key_out, err, err_code, ser_ready, busy, exp_key);
            end
        end
        $display("load %s frames=%0d exp_fail=%0d beats=%0d cycles=%0d key_out=%h",
                 name, exp_idx + 1, exp_fail, beats, cycles, key_out);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        start     = 1'b0;
        zeroize   = 1'b0;
        ser_valid = 1'b0;
        ser_bit   = 1'b0;
        #12;
        checks++;
        if (key_out !== '0 || key_valid !== 1'b0 || ser_ready !== 1'b0 || busy !== 1'b0 ||
            err !== 1'b0 || err_code !== 2'd0) begin
            errors++;
            $display("FAIL reset got key=%h kv=%b rdy=%b busy=%b err=%b code=%0d want all 0",
                     key_out, key_valid, ser_ready, busy, err, err_code);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || key_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got busy=%b kv=%b want 0/0", busy, key_valid);
        end
        $display("reset done");
    endtask

    task automatic test_clean_load();
        fr_key.delete(); fr_par.delete();
        fr_key.push_back(16'hA5C3);
        fr_par.push_back(1'b0);
        do_load(1'b1, 100, 1'b0, "clean_a5c3");
    endtask

    task automatic test_retry_then_lock();
        fr_key.delete(); fr_par.delete();
        for (int i = 0; i < 3; i++) begin
            fr_key.push_back(16'hA5C3);
            fr_par.push_back(1'b1);
        end
        fr_key.push_back(16'hA5C3);
        fr_par.push_back(1'b0);
        do_load(1'b1, 100, 1'b0, "retry3_lock");
    endtask

    task automatic test_parity_exhausted();
        fr_key.delete(); fr_par.delete();
        for (int i = 0; i < 4; i++) push_frame(16'($urandom), 1'b0);
        do_load(1'b1, 80, 1'b0, "parity_exhausted");
    endtask

    task automatic test_random_loads();
        int nf;
        for (int t = 0; t < 8; t++) begin
            fr_key.delete(); fr_par.delete();
            nf = $urandom_range(0, 4);
            for (int i = 0; i < nf; i++) push_frame(16'($urandom), 1'b0);
            if (nf < 4) push_frame(16'($urandom), 1'b1);
            do_load(1'b1, $urandom_range(40, 100), 1'($urandom), "random");
        end
    endtask

    // Loading aborts on the 255th consecutive cycle without a beat.
    task automatic test_timeout();
        @(negedge clk);
        zeroize = 1'b1;
        @(negedge clk);
        zeroize = 1'b0;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ser_valid = 1'b1;
            ser_bit   = 1'($urandom);
            @(negedge clk);
        end
        ser_valid = 1'b0;
        for (int i = 1; i <= 254; i++) @(negedge clk);
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_254_idle got err=%b busy=%b want 0/1", err, busy);
        end
        ser_valid = 1'b1;
        ser_bit   = 1'($urandom);
        @(negedge clk);
        ser_valid = 1'b0;
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_beat_saves got err=%b busy=%b want 0/1", err, busy);
        end
        for (int i = 1; i <= 254; i++) @(negedge clk);
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early got err=%b busy=%b want 0/1", err, busy);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || err_code !== 2'd2 || busy !== 1'b0 || ser_ready !== 1'b0 ||
            key_valid !== 1'b0 || key_out !== '0) begin
            errors++;
            $display("FAIL timeout_fire got err=%b code=%0d busy=%b rdy=%b kv=%b key=%h want 1/2/0/0/0/0000",
                     err, err_code, busy, ser_ready, key_valid, key_out);
        end
        $display("timeout err=%b err_code=%0d", err, err_code);
    endtask

    // Restart straight from ERROR with start: error flags must clear.
    task automatic test_restart_from_error();
        fr_key.delete(); fr_par.delete();
        push_frame(16'($urandom), 1'b1);
        do_load(1'b0, 90, 1'b0, "restart_from_error");
    endtask

    task automatic test_zeroize_locked();
        logic [KW-1:0] held;
        held = key_out;
        @(negedge clk);
        start     = 1'b1;
        ser_valid = 1'b1;
        repeat (3) @(negedge clk);
        start     = 1'b0;
        ser_valid = 1'b0;
        checks++;
        if (key_valid !== 1'b1 || busy !== 1'b0 || key_out !== held) begin
            errors++;
            $display("FAIL locked_ignores_start got kv=%b busy=%b key=%h want 1/0/%h",
                     key_valid, busy, key_out, held);
        end
        zeroize = 1'b1;
        @(negedge clk);
        zeroize = 1'b0;
        checks++;
        if (key_valid !== 1'b0 || key_out !== '0 || busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL zeroize_locked got kv=%b key=%h busy=%b err=%b want 0/0000/0/0",
                     key_valid, key_out, busy, err);
        end
        $display("zeroize_locked key_out=%h", key_out);
    endtask

    task automatic test_zeroize_mid_shift();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ser_valid = 1'b1;
            ser_bit   = 1'($urandom);
            @(negedge clk);
        end
        zeroize = 1'b1;
        @(negedge clk);
        zeroize   = 1'b0;
        ser_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || ser_ready !== 1'b0 || key_valid !== 1'b0 || key_out !== '0) begin
            errors++;
            $display("FAIL zeroize_mid_shift got busy=%b rdy=%b kv=%b key=%h want 0/0/0/0000",
                     busy, ser_ready, key_valid, key_out);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL zeroize_stays_idle got busy=%b want 0", busy);
        end
        $display("zeroize_mid_shift busy=%b", busy);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ser_valid = 1'b1;
            ser_bit   = 1'($urandom);
            @(negedge clk);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || ser_ready !== 1'b0 || key_valid !== 1'b0 || key_out !== '0 ||
            err !== 1'b0 || err_code !== 2'd0) begin
            errors++;
            $display("FAIL async_reset got busy=%b rdy=%b kv=%b key=%h err=%b code=%0d want all 0",
                     busy, ser_ready, key_valid, key_out, err, err_code);
        end
        ser_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        $display("async_reset busy=%b", busy);
        fr_key.delete(); fr_par.delete();
        push_frame(16'($urandom), 1'b1);
        do_load(1'b0, 100, 1'b0, "reload_after_reset");
    endtask

    initial begin
        test_reset();
        test_clean_load();
        test_zeroize_locked();
        test_retry_then_lock();
        test_parity_exhausted();
        test_random_loads();
        test_timeout();
        test_restart_from_error();
        test_zeroize_mid_shift();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
